// File: rtl/cdr_pkg.sv
// Shared CDR datapath constants and helpers for the delay-line family.
package cdr_pkg;

  localparam int unsigned DLY_DEPTH_MAX = 64;
  localparam int unsigned FILL_W_MAX    = $clog2(DLY_DEPTH_MAX + 1);

  // Wide enough to hold a fill count for any legal delay-line depth
  typedef logic [FILL_W_MAX-1:0] fill_t;

  function automatic int unsigned tap_w(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dly_stage.sv
// One WIDTH-bit delay-line register with sync reset, sync clear and load enable.
module dly_stage
  import cdr_pkg::*;
#(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_delay_line.sv
// Enable-gated register delay line with runtime tap select and fill-tracking valid.
// Optional fill counter / valid tracking is built when DFF_DELAY_LINE_VALID_EN is defined.
module dff_delay_line
  import cdr_pkg::*;
#(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int unsigned     TAP_W   = tap_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             flush,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift chain: stage 0 takes the input sample, every later stage its predecessor
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] din;

    if (i == 0) begin : g_head
      assign din = d;
    end else begin : g_tail
      assign din = stage[i-1];
    end

    dly_stage #(
      .WIDTH  (WIDTH),
      .RST_VAL(RST_VAL)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .clr(flush),
      .en (en),
      .d  (din),
      .q  (stage[i])
    );
  end

  // Tap mux; a tap past the last stage reads as the reset value
  always_comb begin
    q = RST_VAL;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TAP_W'(i)) begin
        q = stage[i];
      end
    end
  end

`ifdef DFF_DELAY_LINE_VALID_EN
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [FILL_W-1:0] fill;

  // Counts enabled shifts since the last clear, saturating once the line is full
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      fill <= '0;
    end else if (en && (fill != FILL_W'(DEPTH))) begin
      fill <= fill + FILL_W'(1);
    end
  end

  // fill never exceeds DEPTH, so an out-of-range tap is never valid
  assign valid = (32'(fill) > 32'(tap_sel));
`else
  assign valid = 1'b1;
`endif

endmodule

// File: tb/tb_dff_delay_line.sv
// Scoreboard bench for dff_delay_line: an 8-deep/0xA5 line and a 5-deep/0x5A line share stimulus.
// Expected valid follows DFF_DELAY_LINE_VALID_EN (tied high when the macro is undefined).
module tb_dff_delay_line;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic       en;
  logic       flush;
  logic [2:0] tap8;
  logic [2:0] tap5;
  logic [7:0] q8;
  logic [7:0] q5;
  logic       valid8;
  logic       valid5;

  int total;
  int bad;

  // Reference line contents, newest sample at index 0
  logic [7:0] line8 [$];
  logic [7:0] line5 [$];
  // In-order expected stream for the latency run
  logic [7:0] sb [$];

  dff_delay_line #(
    .WIDTH  (8),
    .DEPTH  (8),
    .RST_VAL(8'hA5)
  ) dut8 (
    .clk    (clk),
    .rst    (rst),
    .d      (d),
    .en     (en),
    .flush  (flush),
    .tap_sel(tap8),
    .q      (q8),
    .valid  (valid8)
  );

  dff_delay_line #(
    .WIDTH  (8),
    .DEPTH  (5),
    .RST_VAL(8'h5A)
  ) dut5 (
    .clk    (clk),
    .rst    (rst),
    .d      (d),
    .en     (en),
    .flush  (flush),
    .tap_sel(tap5),
    .q      (q5),
    .valid  (valid5)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_q8(input int k);
    return (k < line8.size()) ? line8[k] : 8'hA5;
  endfunction

  function automatic logic [7:0] exp_q5(input int k);
    return (k < line5.size()) ? line5[k] : 8'h5A;
  endfunction

  function automatic logic exp_v8(input int k);
`ifdef DFF_DELAY_LINE_VALID_EN
    return k < line8.size();
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic exp_v5(input int k);
`ifdef DFF_DELAY_LINE_VALID_EN
    return k < line5.size();
`else
    return 1'b1;
`endif
  endfunction

  // Advance one edge and update the reference with the inputs the DUT sampled
  task automatic tick();
    @(posedge clk);
    if (rst || flush) begin
      line8.delete();
      line5.delete();
    end else if (en) begin
      line8.push_front(d);
      line5.push_front(d);
      if (line8.size() > 8) void'(line8.pop_back());
      if (line5.size() > 5) void'(line5.pop_back());
    end
    #1;
  endtask

  task automatic check_taps(input string tag);
    for (int k = 0; k < 8; k++) begin
      tap8 = 3'(k);
      tap5 = 3'(k);
      #1;
      chk({tag, "_q8"}, 32'(q8), 32'(exp_q8(k)));
      chk({tag, "_v8"}, 32'(valid8), 32'(exp_v8(k)));
      chk({tag, "_q5"}, 32'(q5), 32'(exp_q5(k)));
      chk({tag, "_v5"}, 32'(valid5), 32'(exp_v5(k)));
    end
  endtask

  task automatic check_tap(input string tag, input int k);
    tap8 = 3'(k);
    tap5 = 3'(k);
    #1;
    chk({tag, "_q8"}, 32'(q8), 32'(exp_q8(k)));
    chk({tag, "_v8"}, 32'(valid8), 32'(exp_v8(k)));
    chk({tag, "_q5"}, 32'(q5), 32'(exp_q5(k)));
    chk({tag, "_v5"}, 32'(valid5), 32'(exp_v5(k)));
  endtask

  initial begin
    int first;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    en    = 1'b0;
    flush = 1'b0;
    d     = 8'h00;
    tap8  = 3'd0;
    tap5  = 3'd0;

    // Reset held two cycles
    tick();
    tick();
    rst = 1'b0;
    check_taps("reset");
    chk("reset_q8_const", 32'(q8), 32'h0000_00A5);

    // Latency with en held high, tap 3
    tap8  = 3'd3;
    tap5  = 3'd3;
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      d  = 8'(i);
      en = 1'b1;
      sb.push_back(8'(i));
      tick();
      #1;
      if (line8.size() > 3) begin
        if (first < 0) first = i;
        chk("lat_q", 32'(q8), 32'(sb.pop_front()));
      end else begin
        chk("lat_pre_q", 32'(q8), 32'h0000_00A5);
      end
      chk("lat_v", 32'(valid8), 32'(exp_v8(3)));
    end
    chk("lat_first_edge", 32'(first), 32'd4);
    en = 1'b0;

    // Enable gaps at tap 2
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int v = 10; v <= 12; v++) begin
      d  = 8'(v);
      en = 1'b1;
      tick();
      check_tap("gap_en", 2);
      en = 1'b0;
      repeat (2) begin
        d = 8'($urandom);
        tick();
        check_tap("gap_idle", 2);
      end
    end
    tap8 = 3'd2;
    #1;
    chk("gap_hold10", 32'(q8), 32'd10);

    // Full line of 0x3C, then flush with en and 0xFF in the same cycle
    d  = 8'h3C;
    en = 1'b1;
    repeat (8) tick();
    check_taps("full");
    flush = 1'b1;
    en    = 1'b1;
    d     = 8'hFF;
    tick();
    flush = 1'b0;
    en    = 1'b0;
    check_taps("flush");

    // Saturation: 20 samples into both lines, sweep every tap
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      tick();
    end
    en = 1'b0;
    check_taps("sat");
    en = 1'b1;
    d  = 8'h42;
    tick();
    en = 1'b0;
    check_taps("sat_more");

    // Reset in the middle of a fill, then restart from one sample
    flush = 1'b1;
    tick();
    flush = 1'b0;
    en    = 1'b1;
    repeat (3) begin
      d = 8'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b0;
    check_taps("rst_mid");
    en = 1'b1;
    d  = 8'h77;
    tick();
    en = 1'b0;
    check_taps("restart");

    // Random traffic with occasional flush and a random tap each cycle
    for (int i = 0; i < 200; i++) begin
      d     = 8'($urandom);
      en    = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      tick();
      flush = 1'b0;
      check_tap("rand", int'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff_delay_line.md
# dff_delay_line

Parametrised, enable-gated register delay line with runtime-selectable tap. It is the multi-bit, multi-stage successor to the single-bit synchronous-reset flip-flop used throughout the CDR datapath. It aligns PRN reference bits and sampled data across the phase-detector and comparison paths. It also provides flush and a fill-tracking valid flag, so downstream logic ignores stale stages after reset or re-lock.

## Interface
- WIDTH, 1 — bits per stage.
- DEPTH, 8 — number of stages; legal range 2..64.
- RST_VAL, '0 — WIDTH-bit value loaded into every stage on `rst` or `flush`.
- TAP_W, derived = max(1, clog2(DEPTH)) — width of `tap_sel`; not user-overridable.
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `d`  in  WIDTH  — input sample.
- `en`  in  1  — shift enable; the line advances only when high.
- `flush`  in  1  — synchronous clear of stages and fill count, without global reset.
- `tap_sel`  in  TAP_W  — selects stage k; output delay is k+1 enabled cycles.
- `q`  out  WIDTH  — selected stage contents.
- `valid`  out  1  — high when stage `tap_sel` holds a real sample (written since the last `rst`/`flush`).

## Operation
- Storage: stage[0..DEPTH-1], each WIDTH bits.
- Update priority per rising edge: `rst` > `flush` > `en` > hold.
  - `rst` or `flush`: all stages ← RST_VAL; fill ← 0.
  - `en` only: stage[0] ← `d`; stage[i] ← stage[i-1] for i ≥ 1; fill ← min(fill+1, DEPTH).
  - Otherwise: all state holds.
- Fill counter: clog2(DEPTH+1) bits; saturates at DEPTH and never wraps.
- `q` = stage[`tap_sel`]. This is a combinational mux from registers; no added register.
- `valid` = (fill > `tap_sel`). This is combinational from registered fill and the live `tap_sel`.
- Out-of-range `tap_sel` (≥ DEPTH, possible when DEPTH is not a power of 2): `q` = RST_VAL and `valid` = 0.
- `flush` and `en` in the same cycle: flush wins and the `d` sample is discarded.
- `rst` in the middle of a fill: the line clears fully on that edge; the next `en` restarts the fill from 1.

## Timing
- Reset values: every stage = RST_VAL; `q` = RST_VAL; `valid` = 0. Both outputs take these values the cycle after `rst` is sampled high.
- Latency: a `d` sampled at an enabled edge n appears on `q` after k+1 enabled edges, with `tap_sel` = k. With `en` held high, that is edge n+k.
- `en` low cycles stretch the delay; they are not counted.
- A `tap_sel` change is visible on `q`/`valid` in the same cycle, with no pipeline.
- `valid` first rises in the cycle after the (k+1)-th enabled edge following `rst`/`flush`.

## Configuration
- `DFF_DELAY_LINE_VALID_EN`:
  - Defined: the fill counter and `valid` are implemented as described.
  - Undefined: the fill counter is not built and `valid` is tied to 1. The out-of-range tap still forces `q` = RST_VAL. Stage, flush and shift behaviour are unchanged.

## Structure
- Shared package `cdr_pkg`:
  - `DLY_DEPTH_MAX` = 64.
  - Function `tap_w(depth)` returning max(1, clog2(depth)).
  - Typedef for the fill count width.
- Sub-module `dly_stage`: one WIDTH-bit register with `clk`, `rst`, `clr`, `en`, `d`, `q` and reset value RST_VAL. It is instantiated DEPTH times in a generate loop.
- The top level holds the fill counter, the tap mux and the `valid` compare.

## Test plan
- Reset: WIDTH=8, DEPTH=8, RST_VAL=8'hA5, `rst` held 2 cycles → `q`=8'hA5 and `valid`=0 for every `tap_sel` 0..7.
- Latency: `en`=1, `tap_sel`=3, `d`=1,2,3,… each cycle from cycle 0 → `q`=1 and `valid`=1 first seen after edge 3; `q` then increments by 1 each cycle.
- Enable gaps: `tap_sel`=2, `d`=10/11/12 on enabled cycles with 2 idle cycles between each → `q`=10 only after the third enabled edge; the value holds during gaps.
- Flush priority: line full of 0x3C, assert `flush` and `en` together with `d`=0xFF → all stages = RST_VAL and `valid`=0 for `tap_sel`=0; 0xFF never appears on `q` at any tap.
- Tap switch and saturation: DEPTH=5, 20 enabled samples, sweep `tap_sel` 0..7 → taps 0..4 return d[n-1..n-5] with `valid`=1; taps 5..7 return RST_VAL with `valid`=0; fill stays at 5.
- Macro off: build without `DFF_DELAY_LINE_VALID_EN`, apply `rst` → `valid`=1 immediately; `q` matches the macro-on build cycle-for-cycle.
